// File: rtl/fir_mac_pkg.sv
// fir_mac_pkg: shared defaults and elaboration-time helpers for the FIR
// multiply-accumulate engine.
//   A_W_DEF/B_W_DEF/ACC_W_DEF/NTAPS_DEF : default operand, accumulator and tap counts
//   clog2()                              : ceiling log2, clog2(1) == 0
//   sat_max()/sat_min()                  : two's complement limits of a signed width,
//                                          returned LIM_W bits wide for later truncation
package fir_mac_pkg;

    localparam int A_W_DEF   = 18;
    localparam int B_W_DEF   = 36;
    localparam int ACC_W_DEF = 68;
    localparam int NTAPS_DEF = 16;

    // Wide enough for any accumulator this engine is likely to be built with.
    localparam int LIM_W = 128;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

    function automatic logic signed [LIM_W-1:0] sat_max(input int width);
        return (128'sd1 <<< (width - 1)) - 128'sd1;
    endfunction

    // Most negative value is the bitwise complement of the most positive one.
    function automatic logic signed [LIM_W-1:0] sat_min(input int width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/fir_mac_sat.sv
// fir_mac_sat: combinational ACC_W -> OUT_W result converter.
// Build option FIR_MAC_SATURATE_EN:
//   defined   : clip to the signed OUT_W range and flag clipping on sat_o
//   undefined : keep the low OUT_W bits (wrap), sat_o tied low
// Ports:
//   acc_i : full-width signed sum
//   mac_o : converted signed result
//   sat_o : 1 when mac_o was clipped
module fir_mac_sat
    import fir_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] mac_o,
    output logic                    sat_o
);

`ifdef FIR_MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(sat_max(OUT_W));
    localparam logic signed [ACC_W-1:0] MIN_S = ACC_W'(sat_min(OUT_W));

    // Clip the sum to the output range; with OUT_W == ACC_W nothing can clip.
    always_comb begin
        mac_o = acc_i[OUT_W-1:0];
        sat_o = 1'b0;
        if (acc_i > MAX_S) begin
            mac_o = MAX_S[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (acc_i < MIN_S) begin
            mac_o = MIN_S[OUT_W-1:0];
            sat_o = 1'b1;
        end else begin
            mac_o = acc_i[OUT_W-1:0];
            sat_o = 1'b0;
        end
    end
`else
    // Upper accumulator bits are intentionally discarded in the wrapping build.
    logic unused_acc_s;
    assign unused_acc_s = ^acc_i;
    assign mac_o        = acc_i[OUT_W-1:0];
    assign sat_o        = 1'b0;
`endif

endmodule

// File: rtl/fir_mac_acc.sv
// fir_mac_acc: pipelined signed multiply-accumulate core for FIR filters.
// Accepts one (A, B) pair per cycle, sums NTAPS consecutive products and
// presents each dot product on MAC_OUT with a valid/ready handshake.
// Pipeline: S1 operand registers, S2 product register, S3 accumulator/output.
// Build option FIR_MAC_SATURATE_EN selects saturating output conversion
// (see fir_mac_sat); the default build wraps to OUT_W bits.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   clear               : abort the partial sum and in-flight pairs
//   in_valid, in_ready  : input handshake, in_ready = !(out_valid && !out_ready)
//   A, B                : signed coefficient and sample
//   out_valid, out_ready: output handshake
//   MAC_OUT, sat        : signed dot product and its clip flag
module fir_mac_acc
    import fir_mac_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = ACC_W_DEF,
    parameter int NTAPS = NTAPS_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [A_W-1:0]   A,
    input  logic signed [B_W-1:0]   B,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] MAC_OUT,
    output logic                    sat
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = (clog2(NTAPS) > 0) ? clog2(NTAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NTAPS - 1);

    if (NTAPS < 1) begin : g_bad_ntaps
        $error("fir_mac_acc: NTAPS must be at least 1");
    end
    if (ACC_W < A_W + B_W + clog2(NTAPS)) begin : g_bad_acc_w
        $error("fir_mac_acc: ACC_W too narrow for NTAPS full-width products");
    end
    if (OUT_W > ACC_W) begin : g_bad_out_w
        $error("fir_mac_acc: OUT_W must not exceed ACC_W");
    end

    logic signed [A_W-1:0]   a_q, a_d;
    logic signed [B_W-1:0]   b_q, b_d;
    logic                    v1_q, v1_d;
    logic signed [P_W-1:0]   prod_q, prod_d;
    logic                    v2_q, v2_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [OUT_W-1:0] mac_q, mac_d;
    logic                    out_valid_q, out_valid_d;
    logic                    sat_q, sat_d;

    logic                    stall_s;
    logic                    last_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [OUT_W-1:0] conv_s;
    logic                    conv_sat_s;

    // A held result with no taker freezes the whole pipeline.
    assign stall_s   = out_valid_q && !out_ready;
    assign in_ready  = !stall_s;
    assign sum_s     = acc_q + ACC_W'(prod_q);
    assign last_s    = v2_q && (cnt_q == LAST_TAP);

    assign out_valid = out_valid_q;
    assign MAC_OUT   = mac_q;
    assign sat       = sat_q;

    fir_mac_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .acc_i (sum_s),
        .mac_o (conv_s),
        .sat_o (conv_sat_s)
    );

    // Next-state logic for the pipeline, tap counter and output register.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        v1_d        = v1_q;
        prod_d      = prod_q;
        v2_d        = v2_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mac_d       = mac_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        if (!stall_s) begin
            a_d    = A;
            b_d    = B;
            prod_d = P_W'(a_q) * P_W'(b_q);
            if (clear) begin
                // Drop the partial sum and everything in flight, including this cycle's pair.
                v1_d  = 1'b0;
                v2_d  = 1'b0;
                acc_d = {ACC_W{1'b0}};
                cnt_d = {CNT_W{1'b0}};
            end else begin
                v1_d = in_valid;
                v2_d = v1_q;
                if (last_s) begin
                    acc_d = {ACC_W{1'b0}};
                    cnt_d = {CNT_W{1'b0}};
                end else if (v2_q) begin
                    acc_d = sum_s;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    acc_d = acc_q;
                    cnt_d = cnt_q;
                end
            end
            // Not stalled implies any held result is being taken this edge,
            // so a completing sum may reload the output back-to-back.
            if (last_s && !clear) begin
                mac_d       = conv_s;
                sat_d       = conv_sat_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q         <= {A_W{1'b0}};
            b_q         <= {B_W{1'b0}};
            v1_q        <= 1'b0;
            prod_q      <= {P_W{1'b0}};
            v2_q        <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            mac_q       <= {OUT_W{1'b0}};
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            v1_q        <= v1_d;
            prod_q      <= prod_d;
            v2_q        <= v2_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mac_q       <= mac_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_acc.sv
// tb_fir_mac_acc: self-checking bench for fir_mac_acc.
// Four instances: u0 NTAPS=4, u1 NTAPS=2, u2 NTAPS=1 (all OUT_W=68) and
// u3 NTAPS=2 OUT_W=40 for the output conversion. Expected results come from
// a dot-product model fed by accepted pairs; FIR_MAC_SATURATE_EN selects the
// expected conversion.
`timescale 1ns/1ps
module tb_fir_mac_acc;

    localparam int NI = 4;

    typedef logic signed [127:0] wide_t;
    typedef struct packed { logic [31:0] edge_n; logic [127:0] prod; } pend_t;
    typedef struct packed { logic [127:0] val; logic sat; } res_t;

    logic clock = 1'b0;
    logic reset;
    logic clear [NI];
    logic in_valid [NI];
    logic out_ready [NI];
    logic signed [17:0] a_s [NI];
    logic signed [35:0] b_s [NI];
    logic in_ready [NI];
    logic out_valid [NI];
    logic sat [NI];
    logic signed [67:0] mac0, mac1, mac2;
    logic signed [39:0] mac3;

    always #5 clock = ~clock;

    fir_mac_acc #(.NTAPS(4)) u0 (
        .clock(clock), .reset(reset), .clear(clear[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .A(a_s[0]), .B(b_s[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .MAC_OUT(mac0), .sat(sat[0]));
    fir_mac_acc #(.NTAPS(2)) u1 (
        .clock(clock), .reset(reset), .clear(clear[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .A(a_s[1]), .B(b_s[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .MAC_OUT(mac1), .sat(sat[1]));
    fir_mac_acc #(.NTAPS(1)) u2 (
        .clock(clock), .reset(reset), .clear(clear[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .A(a_s[2]), .B(b_s[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .MAC_OUT(mac2), .sat(sat[2]));
    fir_mac_acc #(.NTAPS(2), .OUT_W(40)) u3 (
        .clock(clock), .reset(reset), .clear(clear[3]), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .A(a_s[3]), .B(b_s[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .MAC_OUT(mac3), .sat(sat[3]));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    pend_t pend_q [NI][$];
    res_t  exp_q  [NI][$];
    wide_t psum [NI];
    int    pcnt [NI];
    int    adv  [NI];
    int    n_acc [NI];
    int    npop [NI];
    wide_t last_val [NI];
    logic  last_sat [NI];
    logic  obs_ov [NI];
    logic  obs_ir [NI];
    logic  obs_sat [NI];
    wide_t obs_mac [NI];

    task automatic check_eq(input string tag, input wide_t got, input wide_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ntaps_of(input int i);
        case (i)
            0:       return 4;
            1:       return 2;
            2:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int outw_of(input int i);
        return (i == 3) ? 40 : 68;
    endfunction

    function automatic wide_t mac_of(input int i);
        case (i)
            0:       return wide_t'(mac0);
            1:       return wide_t'(mac1);
            2:       return wide_t'(mac2);
            default: return wide_t'(mac3);
        endcase
    endfunction

    // Exact dot product mapped onto the OUT_W result range.
    function automatic res_t conv(input wide_t s, input int ow);
        res_t  r;
        wide_t mx;
        wide_t mn;
        wide_t modv;
        wide_t low;
        mx   = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
        mn   = -mx - wide_t'(1);
        modv = wide_t'(1) <<< ow;
`ifdef FIR_MAC_SATURATE_EN
        r.sat = 1'b1;
        if (s > mx)      r.val = mx;
        else if (s < mn) r.val = mn;
        else begin
            r.val = s;
            r.sat = 1'b0;
        end
`else
        low = s & (modv - wide_t'(1));
        if (low > mx) low = low - modv;
        r.val = low;
        r.sat = 1'b0;
`endif
        return r;
    endfunction

    // One clock cycle: check outputs, advance the model for the coming edge.
    task automatic tick();
        #1;
        for (int i = 0; i < NI; i++) begin
            logic stall_v;
            res_t r;
            pend_t p;
            obs_ov[i]  = out_valid[i];
            obs_ir[i]  = in_ready[i];
            obs_sat[i] = sat[i];
            obs_mac[i] = mac_of(i);
            stall_v    = out_valid[i] && !out_ready[i];
            if (!reset) begin
                check_eq($sformatf("u%0d_in_ready", i), wide_t'(in_ready[i]), wide_t'(!stall_v));
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check_eq($sformatf("u%0d_spurious_out", i), wide_t'(out_valid[i]), wide_t'(0));
                    end else begin
                        r = exp_q[i].pop_front();
                        check_eq($sformatf("u%0d_mac", i), obs_mac[i], $signed(r.val));
                        check_eq($sformatf("u%0d_sat", i), wide_t'(sat[i]), wide_t'(r.sat));
                        npop[i]++;
                        last_val[i] = obs_mac[i];
                        last_sat[i] = sat[i];
                    end
                end
            end
            if (reset) begin
                pend_q[i].delete();
                exp_q[i].delete();
                psum[i] = '0;
                pcnt[i] = 0;
                adv[i]  = 0;
            end else if (!stall_v) begin
                adv[i]++;
                if (clear[i]) begin
                    pend_q[i].delete();
                    psum[i] = '0;
                    pcnt[i] = 0;
                end else begin
                    // An accepted pair reaches the sum two advancing edges later.
                    if (pend_q[i].size() > 0 && pend_q[i][0].edge_n + 2 == adv[i]) begin
                        p = pend_q[i].pop_front();
                        psum[i] = psum[i] + $signed(p.prod);
                        pcnt[i]++;
                        if (pcnt[i] == ntaps_of(i)) begin
                            exp_q[i].push_back(conv(psum[i], outw_of(i)));
                            psum[i] = '0;
                            pcnt[i] = 0;
                        end
                    end
                    if (in_valid[i]) begin
                        p.edge_n = adv[i];
                        p.prod   = wide_t'(a_s[i]) * wide_t'(b_s[i]);
                        pend_q[i].push_back(p);
                        n_acc[i]++;
                    end
                end
            end
        end
        @(negedge clock);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            clear[i]     = 1'b0;
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            a_s[i]       = '0;
            b_s[i]       = '0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        wide_t truesum;
        wide_t expv;
        for (int i = 0; i < NI; i++) begin
            psum[i] = '0; pcnt[i] = 0; adv[i] = 0; n_acc[i] = 0; npop[i] = 0;
            last_val[i] = '0; last_sat[i] = 1'b0;
        end
        idle_all();
        reset = 1'b1;
        @(negedge clock);
        #1;
        run(2);
        reset = 1'b0;
        tick();
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("u%0d_rst_valid", i), wide_t'(obs_ov[i]), wide_t'(0));
            check_eq($sformatf("u%0d_rst_mac", i), obs_mac[i], wide_t'(0));
            check_eq($sformatf("u%0d_rst_sat", i), wide_t'(obs_sat[i]), wide_t'(0));
            check_eq($sformatf("u%0d_rst_ready", i), wide_t'(obs_ir[i]), wide_t'(1));
        end

        // A = 1..4, B = 10 on u0: 100, visible 3 edges after the last accept.
        for (int k = 1; k <= 4; k++) begin
            in_valid[0] = 1'b1; a_s[0] = 18'(k); b_s[0] = 36'sd10;
            tick();
        end
        in_valid[0] = 1'b0;
        tick();
        check_eq("t1_valid_k1", wide_t'(obs_ov[0]), wide_t'(0));
        tick();
        check_eq("t1_valid_k2", wide_t'(obs_ov[0]), wide_t'(0));
        tick();
        check_eq("t1_valid_k3", wide_t'(obs_ov[0]), wide_t'(1));
        check_eq("t1_mac", obs_mac[0], wide_t'(100));
        tick();
        check_eq("t1_valid_k4", wide_t'(obs_ov[0]), wide_t'(0));

        // Four products of the two most negative operands: 4 * 2^52 = 2^54.
        base = npop[0];
        for (int k = 0; k < 4; k++) begin
            in_valid[0] = 1'b1; a_s[0] = 18'sh20000; b_s[0] = 36'sh800000000;
            tick();
        end
        in_valid[0] = 1'b0;
        run(5);
        check_eq("t2_count", wide_t'(npop[0] - base), wide_t'(1));
        check_eq("t2_mac", last_val[0], wide_t'(1) <<< 54);

        // u1 stalled by out_ready=0 while six unit pairs are offered.
        base = npop[1];
        out_ready[1] = 1'b0;
        n_acc[1] = 0;
        for (int j = 0; j < 40; j++) begin
            in_valid[1] = (n_acc[1] < 6); a_s[1] = 18'sd1; b_s[1] = 36'sd1;
            if (j == 10) out_ready[1] = 1'b1;
            tick();
            if (j == 8) begin
                check_eq("t3_held_valid", wide_t'(obs_ov[1]), wide_t'(1));
                check_eq("t3_held_mac", obs_mac[1], wide_t'(2));
                check_eq("t3_in_ready", wide_t'(obs_ir[1]), wide_t'(0));
            end
        end
        check_eq("t3_results", wide_t'(npop[1] - base), wide_t'(3));
        check_eq("t3_last", last_val[1], wide_t'(2));

        // Two taps of 25, clear (with a discarded pair), then four taps of 1.
        idle_all();
        base = npop[0];
        for (int k = 0; k < 2; k++) begin
            in_valid[0] = 1'b1; a_s[0] = 18'sd5; b_s[0] = 36'sd5;
            tick();
        end
        clear[0] = 1'b1; a_s[0] = 18'sd9; b_s[0] = 36'sd9;
        tick();
        clear[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid[0] = 1'b1; a_s[0] = 18'sd1; b_s[0] = 36'sd1;
            tick();
        end
        in_valid[0] = 1'b0;
        run(6);
        check_eq("t4_count", wide_t'(npop[0] - base), wide_t'(1));
        check_eq("t4_mac", last_val[0], wide_t'(4));

        // Reset after three taps: the fourth tap must not complete a block.
        base = npop[0];
        for (int k = 0; k < 3; k++) begin
            in_valid[0] = 1'b1; a_s[0] = 18'sd3; b_s[0] = 36'sd3;
            tick();
        end
        in_valid[0] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        run(6);
        check_eq("t4r_count", wide_t'(npop[0] - base), wide_t'(0));
        check_eq("t4r_valid", wide_t'(obs_ov[0]), wide_t'(0));
        check_eq("t4r_mac", obs_mac[0], wide_t'(0));
        check_eq("t4r_sat", wide_t'(obs_sat[0]), wide_t'(0));

        // Two maximal products into the 40-bit instance.
        base = npop[3];
        for (int k = 0; k < 2; k++) begin
            in_valid[3] = 1'b1; a_s[3] = 18'sh1FFFF; b_s[3] = 36'sh7FFFFFFFF;
            tick();
        end
        in_valid[3] = 1'b0;
        run(5);
        truesum = wide_t'(2) * wide_t'(131071) * wide_t'(64'sd34359738367);
`ifdef FIR_MAC_SATURATE_EN
        expv = (wide_t'(1) <<< 39) - wide_t'(1);
        check_eq("t5_sat", wide_t'(last_sat[3]), wide_t'(1));
`else
        expv = truesum & ((wide_t'(1) <<< 40) - wide_t'(1));
        if (expv >= (wide_t'(1) <<< 39)) expv = expv - (wide_t'(1) <<< 40);
        check_eq("t5_sat", wide_t'(last_sat[3]), wide_t'(0));
`endif
        check_eq("t5_count", wide_t'(npop[3] - base), wide_t'(1));
        check_eq("t5_mac", last_val[3], expv);

        // NTAPS=1: every pair is a result, output valid every cycle.
        base = npop[2];
        for (int j = 0; j < 30; j++) begin
            in_valid[2] = 1'b1; a_s[2] = 18'(j); b_s[2] = 36'sd2;
            tick();
            if (j >= 3) begin
                check_eq("t6_valid", wide_t'(obs_ov[2]), wide_t'(1));
                check_eq("t6_mac", obs_mac[2], wide_t'(2 * (j - 3)));
            end
        end
        in_valid[2] = 1'b0;
        run(4);
        check_eq("t6_count", wide_t'(npop[2] - base), wide_t'(30));

        // Random traffic, back-pressure, clears and occasional resets.
        for (int j = 0; j < 3000; j++) begin
            reset = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NI; i++) begin
                in_valid[i]  = ($urandom_range(0, 3) != 0);
                out_ready[i] = ($urandom_range(0, 3) != 0);
                clear[i]     = ($urandom_range(0, 49) == 0);
                a_s[i]       = 18'($urandom);
                b_s[i]       = 36'({$urandom, $urandom});
            end
            tick();
        end
        reset = 1'b0;
        idle_all();
        run(12);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("u%0d_drained", i), wide_t'(exp_q[i].size()), wide_t'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
